// File: rtl/mult_arb_pkg.sv
// Shared encodings for the multiplier arbiter/sequencer (mult_arb_seq).
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_AGU = 1'b1;

endpackage

// File: rtl/mult_arb_pick.sv
// Combinational 2-way requester picker. Round-robin tie-break when
// MULT_ARB_RR_EN is defined, otherwise requester 0 always wins ties.
module mult_arb_pick
  import mult_arb_pkg::*;
(
  input  logic       Req0,
  input  logic       Req1,
`ifdef MULT_ARB_RR_EN
  input  logic       Ptr,
`endif
  output logic [1:0] Grant,
  output logic       GntId
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    GntId = REQ_ALU;
    Grant = 2'b00;
`ifdef MULT_ARB_RR_EN
    if (Req0 && Req1) GntId = Ptr;
    else if (Req1)    GntId = REQ_AGU;
`else
    if (!Req0 && Req1) GntId = REQ_AGU;
`endif
    if (Req0 || Req1) Grant = (GntId == REQ_AGU) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mult_arb_seq.sv
// Arbiter/sequencer in front of the shared shift-add multiplier.
// Define MULT_ARB_RR_EN for round-robin tie-breaking; default is fixed priority.
module mult_arb_seq
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Req0,
  input  logic               Req1,
  input  logic [WIDTH-1:0]   A0,
  input  logic [WIDTH-1:0]   B0,
  input  logic [WIDTH-1:0]   A1,
  input  logic [WIDTH-1:0]   B1,
  output logic               Ack0,
  output logic               Ack1,
  output logic               MulSt,
  output logic [WIDTH-1:0]   MulMcand,
  output logic [WIDTH-1:0]   MulMplier,
  input  logic               MulIdle,
  input  logic               MulDone,
  input  logic [2*WIDTH-1:0] MulProduct,
  output logic               RspValid,
  output logic               RspId,
  output logic [2*WIDTH-1:0] RspProduct,
  output logic               Busy
);

  state_t     state;
  logic       owner;
  logic [1:0] grant;
  logic       gnt_id;

`ifdef MULT_ARB_RR_EN
  logic ptr;
`endif

  mult_arb_pick u_pick (
    .Req0  (Req0),
    .Req1  (Req1),
`ifdef MULT_ARB_RR_EN
    .Ptr   (ptr),
`endif
    .Grant (grant),
    .GntId (gnt_id)
  );

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the reset
    // clears every register, since all of them drive outputs or control.
    if (Rst) begin
      state      <= IDLE;
      owner      <= REQ_ALU;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      MulSt      <= 1'b0;
      MulMcand   <= '0;
      MulMplier  <= '0;
      RspValid   <= 1'b0;
      RspId      <= 1'b0;
      RspProduct <= '0;
      Busy       <= 1'b0;
`ifdef MULT_ARB_RR_EN
      ptr        <= REQ_ALU;
`endif
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      MulSt    <= 1'b0;
      RspValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (MulIdle && (grant != 2'b00)) begin
            Ack0      <= grant[0];
            Ack1      <= grant[1];
            MulMcand  <= (gnt_id == REQ_AGU) ? A1 : A0;
            MulMplier <= (gnt_id == REQ_AGU) ? B1 : B0;
            owner     <= gnt_id;
            MulSt     <= 1'b1;
            Busy      <= 1'b1;
            state     <= ISSUE;
`ifdef MULT_ARB_RR_EN
            ptr       <= ~gnt_id;
`endif
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (MulDone) begin
            RspProduct <= MulProduct;
            RspValid   <= 1'b1;
            RspId      <= owner;
            state      <= RESP;
          end
        end
        RESP: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
